// File: rtl/bram_port_adapter_if.sv
// Request, response and RAM-port signals of bram_port_adapter, bundled so the
// pipeline side, the adapter and the RAM model can share one connection.
interface bram_port_adapter_if #(
  parameter int unsigned RAM_WIDTH = 32,
  parameter int unsigned AW        = 10
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [AW-1:0]        req_addr;
  logic [RAM_WIDTH-1:0] req_wdata;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [RAM_WIDTH-1:0] resp_rdata;
  logic                 bram_ena;
  logic                 bram_wea;
  logic [AW-1:0]        bram_addra;
  logic [RAM_WIDTH-1:0] bram_dina;
  logic [RAM_WIDTH-1:0] bram_douta;

  // Adapter side: takes requests and RAM data, produces responses and RAM controls
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready, bram_douta,
    output req_ready, resp_valid, resp_rdata, bram_ena, bram_wea, bram_addra, bram_dina
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready, bram_douta,
    input  req_ready, resp_valid, resp_rdata, bram_ena, bram_wea, bram_addra, bram_dina
  );
endinterface

// File: rtl/bram_port_adapter.sv
// Valid/ready front end for a single-port read-first BRAM with one-cycle read
// latency; a 2-entry response buffer catches RAM output under backpressure.
module bram_port_adapter #(
  parameter int unsigned RAM_WIDTH  = 32,
  parameter int unsigned RAM_DEPTH  = 1024,
  parameter bit          WRITE_RESP = 1'b0
) (
  input logic                clka,
  input logic                rsta_n,
  bram_port_adapter_if.slave bus
);

  localparam int unsigned AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

  logic                 inflight_q, inflight_d;
  logic [1:0]           count_q, count_d;
  logic                 rdPtr_q, rdPtr_d;
  logic                 wrPtr_q, wrPtr_d;
  logic [RAM_WIDTH-1:0] fifo_q [2];

  logic [1:0] occupancy;
  logic       fire;
  logic       pop;
  logic       fifoPop;
  logic       push;

  // Credit is taken from registered state only, so resp_ready never reaches req_ready
  assign occupancy     = count_q + {1'b0, inflight_q};
  assign bus.req_ready = rsta_n & (occupancy < 2'd2);
  assign fire          = bus.req_valid & bus.req_ready;

  assign bus.bram_ena   = fire;
  assign bus.bram_wea   = fire & bus.req_we;
  assign bus.bram_addra = AW'(bus.req_addr);
  assign bus.bram_dina  = bus.req_wdata;

  // With an empty buffer the RAM output is bypassed straight to the consumer
  assign bus.resp_valid = (count_q != 2'd0) | inflight_q;
  assign bus.resp_rdata = (count_q != 2'd0) ? fifo_q[rdPtr_q] : bus.bram_douta;

  assign pop     = bus.resp_valid & bus.resp_ready;
  assign fifoPop = pop & (count_q != 2'd0);
  assign push    = inflight_q & ((count_q != 2'd0) | ~bus.resp_ready);

  always_comb begin
    inflight_d = fire & (~bus.req_we | WRITE_RESP);
    count_d    = count_q + {1'b0, push} - {1'b0, fifoPop};
    rdPtr_d    = rdPtr_q ^ fifoPop;
    wrPtr_d    = wrPtr_q ^ push;
  end

  always_ff @(posedge clka or negedge rsta_n) begin
    if (!rsta_n) begin
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      rdPtr_q    <= 1'b0;
      wrPtr_q    <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
    end
  end

  // Push samples the pre-edge RAM output, so a same-edge new access cannot clobber it
  always_ff @(posedge clka) begin
    if (push) begin
      fifo_q[wrPtr_q] <= bus.bram_douta;
    end
  end

endmodule

// File: tb/tb_bram_port_adapter.sv
// Directed bench for bram_port_adapter: one DUT without and one with write
// responses, each attached to a behavioural read-first one-cycle BRAM.
module tb_bram_port_adapter;

  logic clka;
  logic rsta_n;
  int   errors;
  int   checks;

  logic [31:0] memA [1024];
  logic [31:0] memB [1024];

  bram_port_adapter_if #(.RAM_WIDTH(32), .AW(10)) ia ();
  bram_port_adapter_if #(.RAM_WIDTH(32), .AW(10)) ib ();

  bram_port_adapter #(.RAM_WIDTH(32), .RAM_DEPTH(1024), .WRITE_RESP(1'b0)) dutA (
    .clka(clka), .rsta_n(rsta_n), .bus(ia)
  );
  bram_port_adapter #(.RAM_WIDTH(32), .RAM_DEPTH(1024), .WRITE_RESP(1'b1)) dutB (
    .clka(clka), .rsta_n(rsta_n), .bus(ib)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // Read-first RAM for DUT A: douta takes the old word, holds between accesses
  initial begin
    for (int i = 0; i < 1024; i++) memA[i] = 32'h1000_0000 + i;
    memA[5] = 32'hA5A5_0001;
    ia.bram_douta = '0;
    forever begin
      @(posedge clka);
      if (ia.bram_ena) begin
        ia.bram_douta <= memA[ia.bram_addra];
        if (ia.bram_wea) memA[ia.bram_addra] <= ia.bram_dina;
      end
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) memB[i] = 32'h2000_0000 + i;
    memB[9] = 32'h0000_0011;
    ib.bram_douta = '0;
    forever begin
      @(posedge clka);
      if (ib.bram_ena) begin
        ib.bram_douta <= memB[ib.bram_addra];
        if (ib.bram_wea) memB[ib.bram_addra] <= ib.bram_dina;
      end
    end
  end

  function automatic logic [31:0] expA(input int a);
    return (a == 5) ? 32'hA5A5_0001 : 32'h1000_0000 + a;
  endfunction

  task automatic driveA(input logic v, input logic we, input logic [9:0] a,
                        input logic [31:0] d, input logic rr);
    ia.req_valid  = v;
    ia.req_we     = we;
    ia.req_addr   = a;
    ia.req_wdata  = d;
    ia.resp_ready = rr;
  endtask

  task automatic driveB(input logic v, input logic we, input logic [9:0] a,
                        input logic [31:0] d, input logic rr);
    ib.req_valid  = v;
    ib.req_we     = we;
    ib.req_addr   = a;
    ib.req_wdata  = d;
    ib.resp_ready = rr;
  endtask

  task automatic test_reset();
    @(negedge clka);
    driveA(1'b1, 1'b1, 10'd0, 32'hDEAD_BEEF, 1'b1);
    #1;
    checks++; if (ia.req_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 0", ia.req_ready); end
    checks++; if (ia.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", ia.resp_valid); end
    checks++; if (ia.bram_ena !== 1'b0 || ia.bram_wea !== 1'b0) begin errors++; $display("[TB] FAIL reset_bram_en: got ena=%b wea=%b expected 0/0", ia.bram_ena, ia.bram_wea); end
    @(negedge clka);
    driveA(1'b0, 1'b0, 10'd0, 32'h0, 1'b1);
    rsta_n = 1'b1;
    #1;
    checks++; if (ia.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_req_ready: got %b expected 1", ia.req_ready); end
    checks++; if (ia.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL release_resp_valid: got %b expected 0", ia.resp_valid); end
  endtask

  task automatic test_single_read();
    @(negedge clka);
    driveA(1'b1, 1'b0, 10'd5, 32'h0, 1'b1);
    #1;
    checks++; if (ia.bram_ena !== 1'b1 || ia.bram_addra !== 10'd5) begin errors++; $display("[TB] FAIL single_issue: got ena=%b addr=%0d expected 1/5", ia.bram_ena, ia.bram_addra); end
    @(negedge clka);
    driveA(1'b0, 1'b0, 10'd0, 32'h0, 1'b1);
    #1;
    checks++; if (ia.resp_valid !== 1'b1 || ia.resp_rdata !== 32'hA5A5_0001) begin errors++; $display("[TB] FAIL single_resp: got v=%b d=%h expected 1/a5a50001", ia.resp_valid, ia.resp_rdata); end
    @(negedge clka);
    #1;
    checks++; if (ia.resp_valid !== 1'b0 || ia.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_idle: got v=%b rdy=%b expected 0/1", ia.resp_valid, ia.req_ready); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i <= 8; i++) begin
      @(negedge clka);
      driveA(i < 8, 1'b0, 10'(i), 32'h0, 1'b1);
      #1;
      if (i < 8) begin
        checks++; if (ia.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready[%0d]: got %b expected 1", i, ia.req_ready); end
      end
      if (i > 0) begin
        checks++; if (ia.resp_valid !== 1'b1 || ia.resp_rdata !== expA(i - 1)) begin errors++; $display("[TB] FAIL b2b_resp[%0d]: got v=%b d=%h expected 1/%h", i - 1, ia.resp_valid, ia.resp_rdata, expA(i - 1)); end
      end
    end
    @(negedge clka);
    driveA(1'b0, 1'b0, 10'd0, 32'h0, 1'b1);
    #1;
    checks++; if (ia.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drained: got %b expected 0", ia.resp_valid); end
  endtask

  task automatic test_backpressure();
    @(negedge clka);
    driveA(1'b1, 1'b0, 10'd1, 32'h0, 1'b0);
    #1;
    checks++; if (ia.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_accept1: got %b expected 1", ia.req_ready); end
    @(negedge clka);
    driveA(1'b1, 1'b0, 10'd2, 32'h0, 1'b0);
    #1;
    checks++; if (ia.req_ready !== 1'b1 || ia.resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_accept2: got rdy=%b v=%b expected 1/1", ia.req_ready, ia.resp_valid); end
    @(negedge clka);
    driveA(1'b1, 1'b0, 10'd3, 32'h0, 1'b0);
    #1;
    checks++; if (ia.req_ready !== 1'b0 || ia.bram_ena !== 1'b0) begin errors++; $display("[TB] FAIL bp_stall: got rdy=%b ena=%b expected 0/0", ia.req_ready, ia.bram_ena); end
    @(negedge clka);
    #1;
    checks++; if (ia.req_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_stall_hold: got %b expected 0", ia.req_ready); end
    @(negedge clka);
    driveA(1'b1, 1'b0, 10'd3, 32'h0, 1'b1);
    #1;
    checks++; if (ia.req_ready !== 1'b0 || ia.resp_rdata !== expA(1)) begin errors++; $display("[TB] FAIL bp_pop1: got rdy=%b d=%h expected 0/%h", ia.req_ready, ia.resp_rdata, expA(1)); end
    @(negedge clka);
    #1;
    checks++; if (ia.req_ready !== 1'b1 || ia.resp_valid !== 1'b1 || ia.resp_rdata !== expA(2)) begin errors++; $display("[TB] FAIL bp_pop2: got rdy=%b v=%b d=%h expected 1/1/%h", ia.req_ready, ia.resp_valid, ia.resp_rdata, expA(2)); end
    @(negedge clka);
    driveA(1'b0, 1'b0, 10'd0, 32'h0, 1'b1);
    #1;
    checks++; if (ia.resp_valid !== 1'b1 || ia.resp_rdata !== expA(3)) begin errors++; $display("[TB] FAIL bp_pop3: got v=%b d=%h expected 1/%h", ia.resp_valid, ia.resp_rdata, expA(3)); end
    @(negedge clka);
    #1;
    checks++; if (ia.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drained: got %b expected 0", ia.resp_valid); end
  endtask

  task automatic test_write_noresp();
    @(negedge clka);
    driveA(1'b1, 1'b0, 10'd3, 32'h0, 1'b1);
    @(negedge clka);
    driveA(1'b1, 1'b1, 10'd4, 32'hDEAD_0004, 1'b1);
    #1;
    checks++; if (ia.bram_wea !== 1'b1 || ia.bram_dina !== 32'hDEAD_0004) begin errors++; $display("[TB] FAIL nr_write_issue: got wea=%b din=%h expected 1/dead0004", ia.bram_wea, ia.bram_dina); end
    checks++; if (ia.resp_valid !== 1'b1 || ia.resp_rdata !== expA(3)) begin errors++; $display("[TB] FAIL nr_read3: got v=%b d=%h expected 1/%h", ia.resp_valid, ia.resp_rdata, expA(3)); end
    @(negedge clka);
    driveA(1'b1, 1'b0, 10'd4, 32'h0, 1'b1);
    #1;
    checks++; if (ia.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL nr_no_write_resp: got %b expected 0", ia.resp_valid); end
    @(negedge clka);
    driveA(1'b0, 1'b0, 10'd0, 32'h0, 1'b1);
    #1;
    checks++; if (ia.resp_valid !== 1'b1 || ia.resp_rdata !== 32'hDEAD_0004) begin errors++; $display("[TB] FAIL nr_read4: got v=%b d=%h expected 1/dead0004", ia.resp_valid, ia.resp_rdata); end
    @(negedge clka);
    #1;
    checks++; if (ia.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL nr_drained: got %b expected 0", ia.resp_valid); end
  endtask

  task automatic test_write_resp();
    @(negedge clka);
    driveB(1'b1, 1'b1, 10'd9, 32'h0000_0022, 1'b1);
    #1;
    checks++; if (ib.req_ready !== 1'b1 || ib.bram_wea !== 1'b1) begin errors++; $display("[TB] FAIL wr_issue: got rdy=%b wea=%b expected 1/1", ib.req_ready, ib.bram_wea); end
    @(negedge clka);
    driveB(1'b1, 1'b0, 10'd9, 32'h0, 1'b1);
    #1;
    checks++; if (ib.resp_valid !== 1'b1 || ib.resp_rdata !== 32'h0000_0011) begin errors++; $display("[TB] FAIL wr_old_data: got v=%b d=%h expected 1/00000011", ib.resp_valid, ib.resp_rdata); end
    @(negedge clka);
    driveB(1'b0, 1'b0, 10'd0, 32'h0, 1'b1);
    #1;
    checks++; if (ib.resp_valid !== 1'b1 || ib.resp_rdata !== 32'h0000_0022) begin errors++; $display("[TB] FAIL wr_new_data: got v=%b d=%h expected 1/00000022", ib.resp_valid, ib.resp_rdata); end
    @(negedge clka);
    #1;
    checks++; if (ib.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL wr_drained: got %b expected 0", ib.resp_valid); end
  endtask

  task automatic test_reset_mid();
    @(negedge clka);
    driveA(1'b1, 1'b0, 10'd6, 32'h0, 1'b0);
    @(negedge clka);
    driveA(1'b1, 1'b0, 10'd7, 32'h0, 1'b0);
    @(negedge clka);
    driveA(1'b0, 1'b0, 10'd0, 32'h0, 1'b0);
    #1;
    checks++; if (ia.resp_valid !== 1'b1 || ia.req_ready !== 1'b0) begin errors++; $display("[TB] FAIL rm_full: got v=%b rdy=%b expected 1/0", ia.resp_valid, ia.req_ready); end
    @(negedge clka);
    driveA(1'b1, 1'b1, 10'd6, 32'hBAD0_BAD0, 1'b0);
    rsta_n = 1'b0;
    #1;
    checks++; if (ia.resp_valid !== 1'b0 || ia.req_ready !== 1'b0) begin errors++; $display("[TB] FAIL rm_flush: got v=%b rdy=%b expected 0/0", ia.resp_valid, ia.req_ready); end
    checks++; if (ia.bram_ena !== 1'b0 || ia.bram_wea !== 1'b0) begin errors++; $display("[TB] FAIL rm_no_write: got ena=%b wea=%b expected 0/0", ia.bram_ena, ia.bram_wea); end
    @(negedge clka);
    driveA(1'b0, 1'b0, 10'd0, 32'h0, 1'b1);
    rsta_n = 1'b1;
    #1;
    checks++; if (ia.req_ready !== 1'b1 || ia.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rm_release: got rdy=%b v=%b expected 1/0", ia.req_ready, ia.resp_valid); end
    @(negedge clka);
    driveA(1'b1, 1'b0, 10'd6, 32'h0, 1'b1);
    @(negedge clka);
    driveA(1'b0, 1'b0, 10'd0, 32'h0, 1'b1);
    #1;
    checks++; if (ia.resp_valid !== 1'b1 || ia.resp_rdata !== expA(6)) begin errors++; $display("[TB] FAIL rm_reread: got v=%b d=%h expected 1/%h", ia.resp_valid, ia.resp_rdata, expA(6)); end
    @(negedge clka);
    #1;
    checks++; if (ia.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rm_drained: got %b expected 0", ia.resp_valid); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rsta_n = 1'b0;
    driveA(1'b0, 1'b0, 10'd0, 32'h0, 1'b1);
    driveB(1'b0, 1'b0, 10'd0, 32'h0, 1'b1);
    test_reset();
    test_single_read();
    test_back_to_back();
    test_backpressure();
    test_write_noresp();
    test_write_resp();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
